// File: rtl/rr_mux_pkg.sv
// Shared constants and lock-state type for the round-robin channel mux.
package rr_mux_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NCH   = 8;
  localparam int MAX_SELW  = 4;

  // Burst lock: while active, round-robin grant is pinned to ch.
  typedef struct packed {
    logic                active;
    logic [MAX_SELW-1:0] ch;
  } lock_t;
endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: the first valid channel at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NCH  = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  in_valid,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] grant,
  output logic            any_valid
);
  logic [2*NCH-1:0] w_rot;
  int               w_idx;

  // Bit k of w_rot is channel (ptr+k) mod NCH.
  assign w_rot = {in_valid, in_valid} >> ptr;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    w_idx     = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_idx = int'(ptr) + k;
        if (w_idx >= NCH) w_idx = w_idx - NCH;
        grant     = SELW'(w_idx);
        any_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_mux_arb.sv
// N-channel mux with fixed or round-robin select feeding one registered output stage.
// Define RR_MUX_LOCK_EN to add in_last and lock round-robin grants for multi-beat bursts.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NCH   = DEF_NCH,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rr_en,
  input  logic [SELW-1:0]      s,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
`ifdef RR_MUX_LOCK_EN
  input  logic [NCH-1:0]       in_last,
`endif
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);
  logic                       r_out_valid;
  logic [WIDTH-1:0]           r_out_data;
  logic [SELW-1:0]            r_out_ch;
  logic [SELW-1:0]            r_ptr;
  logic [NCH-1:0][WIDTH-1:0]  w_ch_data;
  logic [SELW-1:0]            w_arb_grant;
  logic                       w_arb_any;
  logic [SELW-1:0]            w_grant;
  logic                       w_gnt_vld;
  logic                       w_load;
  logic                       w_xfer;
  logic [SELW-1:0]            w_ptr_nxt;

  assign w_ch_data = in_data;
  assign w_load    = !r_out_valid || out_ready;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .in_valid  (in_valid),
    .ptr       (r_ptr),
    .grant     (w_arb_grant),
    .any_valid (w_arb_any)
  );

`ifdef RR_MUX_LOCK_EN
  lock_t r_lock;
  always_comb begin
    w_grant   = s;
    w_gnt_vld = (32'(s) < NCH);
    if (rr_en) begin
      if (r_lock.active) begin
        w_grant   = SELW'(r_lock.ch);
        w_gnt_vld = 1'b1;
      end else begin
        w_grant   = w_arb_grant;
        w_gnt_vld = w_arb_any;
      end
    end
  end
`else
  always_comb begin
    w_grant   = s;
    w_gnt_vld = (32'(s) < NCH);
    if (rr_en) begin
      w_grant   = w_arb_grant;
      w_gnt_vld = w_arb_any;
    end
  end
`endif

  assign in_ready  = (w_gnt_vld && w_load && !rst) ? (NCH'(1) << w_grant) : '0;
  assign w_xfer    = |(in_valid & in_ready);
  assign w_ptr_nxt = (w_grant == SELW'(NCH - 1)) ? '0 : w_grant + SELW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
`ifdef RR_MUX_LOCK_EN
      r_lock      <= '0;
`endif
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ch_data[w_grant];
      r_out_ch    <= w_grant;
`ifdef RR_MUX_LOCK_EN
      // Pointer moves only when a burst closes; fixed mode leaves lock untouched.
      if (rr_en) begin
        if (in_last[w_grant]) begin
          r_ptr         <= w_ptr_nxt;
          r_lock.active <= 1'b0;
        end else begin
          r_lock.active <= 1'b1;
          r_lock.ch     <= MAX_SELW'(w_grant);
        end
      end
`else
      if (rr_en) r_ptr <= w_ptr_nxt;
`endif
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: an 8-channel and a 5-channel instance share one clock.
module tb_rr_mux_arb;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-channel instance
  logic         rst_a, rr_en_a, out_ready_a, out_valid_a;
  logic [2:0]   s_a, out_ch_a;
  logic [7:0]   in_valid_a, in_ready_a;
  logic [255:0] in_data_a;
  logic [31:0]  out_data_a;
`ifdef RR_MUX_LOCK_EN
  logic [7:0]   in_last_a;
`endif

  // 5-channel instance
  logic         rst_b, rr_en_b, out_ready_b, out_valid_b;
  logic [2:0]   s_b, out_ch_b;
  logic [4:0]   in_valid_b, in_ready_b;
  logic [159:0] in_data_b;
  logic [31:0]  out_data_b;
`ifdef RR_MUX_LOCK_EN
  logic [4:0]   in_last_b;
`endif

  rr_mux_arb #(.WIDTH(32), .NCH(8)) u_a (
    .clk(clk), .rst(rst_a), .rr_en(rr_en_a), .s(s_a),
    .in_valid(in_valid_a), .in_data(in_data_a),
`ifdef RR_MUX_LOCK_EN
    .in_last(in_last_a),
`endif
    .in_ready(in_ready_a), .out_valid(out_valid_a), .out_data(out_data_a),
    .out_ch(out_ch_a), .out_ready(out_ready_a)
  );

  rr_mux_arb #(.WIDTH(32), .NCH(5)) u_b (
    .clk(clk), .rst(rst_b), .rr_en(rr_en_b), .s(s_b),
    .in_valid(in_valid_b), .in_data(in_data_b),
`ifdef RR_MUX_LOCK_EN
    .in_last(in_last_b),
`endif
    .in_ready(in_ready_b), .out_valid(out_valid_b), .out_data(out_data_b),
    .out_ch(out_ch_b), .out_ready(out_ready_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) in_data_a[i*32 +: 32] = 32'h100 + i;
    for (int i = 0; i < 5; i++) in_data_b[i*32 +: 32] = 32'h200 + i;
`ifdef RR_MUX_LOCK_EN
    in_last_a = 8'hff;
    in_last_b = 5'h1f;
`endif
    rst_b = 1'b1; rr_en_b = 1'b1; s_b = 3'd0; in_valid_b = 5'b0; out_ready_b = 1'b1;

    // reset with all channels requesting
    rst_a = 1'b1; rr_en_a = 1'b1; s_a = 3'd0; in_valid_a = 8'hff; out_ready_a = 1'b1;
    tick; tick;
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_out_data",  out_data_a, 0);
    chk("rst_in_ready",  in_ready_a, 0);
    rst_a = 1'b0;
    #1 chk("post_rst_ready", in_ready_a, 8'h01);
    tick;
    chk("first_ch",    out_ch_a, 0);
    chk("first_data",  out_data_a, 32'h100);
    chk("first_valid", out_valid_a, 1);

    // round-robin fairness: 1..7 then wrap to 0, one beat per cycle
    for (int k = 1; k <= 8; k++) begin
      tick;
      chk($sformatf("rr_ch%0d", k),    out_ch_a, k % 8);
      chk($sformatf("rr_data%0d", k),  out_data_a, 32'h100 + (k % 8));
      chk($sformatf("rr_valid%0d", k), out_valid_a, 1);
    end

    // fixed select s=5
    rr_en_a = 1'b0; s_a = 3'd5;
    #1 chk("fix_ready", in_ready_a, 8'b0010_0000);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("fix_data%0d", k), out_data_a, 32'h105);
      chk($sformatf("fix_ch%0d", k),   out_ch_a, 5);
    end

    // backpressure: held beat must not move, then replace with no bubble
    s_a = 3'd2; out_ready_a = 1'b0;
    #1 chk("bp_ready0", in_ready_a, 0);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("bp_data%0d", k),  out_data_a, 32'h105);
      chk($sformatf("bp_ch%0d", k),    out_ch_a, 5);
      chk($sformatf("bp_valid%0d", k), out_valid_a, 1);
      chk($sformatf("bp_ready%0d", k), in_ready_a, 0);
    end
    out_ready_a = 1'b1;
    #1 chk("bp_release_ready", in_ready_a, 8'h04);
    tick;
    chk("bp_repl_data",  out_data_a, 32'h102);
    chk("bp_repl_valid", out_valid_a, 1);

    // back to round robin: ptr stayed at 1 through fixed mode
    rr_en_a = 1'b1;
    #1 chk("rr_resume_ready", in_ready_a, 8'h02);
    tick;
    chk("rr_resume_ch", out_ch_a, 1);

    // idle: drain, data/ch hold
    in_valid_a = 8'h00;
    #1 chk("idle_ready", in_ready_a, 0);
    tick;
    chk("idle_valid", out_valid_a, 0);
    chk("idle_data",  out_data_a, 32'h101);
    chk("idle_ch",    out_ch_a, 1);

    // reset while a beat is held
    in_valid_a = 8'hff; out_ready_a = 1'b0;
    tick;
    chk("mid_ch", out_ch_a, 2);
    rst_a = 1'b1;
    tick;
    rst_a = 1'b0; in_valid_a = 8'h00;
    chk("mid_rst_valid", out_valid_a, 0);
    chk("mid_rst_data",  out_data_a, 0);
    chk("mid_rst_ch",    out_ch_a, 0);
    tick;
    chk("mid_rst_stay", out_valid_a, 0);

`ifdef RR_MUX_LOCK_EN
    // lock: ch2 bursts three beats while ch3 waits
    rst_a = 1'b1; out_ready_a = 1'b1; tick; rst_a = 1'b0;
    in_valid_a = 8'b0000_1100; in_last_a = 8'h00;
    tick;
    chk("lock_b1", out_ch_a, 2);
    chk("lock_hold_ready", in_ready_a, 8'h04);
    tick;
    chk("lock_b2", out_ch_a, 2);
    in_last_a = 8'h04;
    tick;
    chk("lock_b3", out_ch_a, 2);
    in_last_a = 8'hff;
    tick;
    chk("lock_next", out_ch_a, 3);
    in_valid_a = 8'h00;
`endif

    // 5 channels, sparse {1,4}: 1 then ptr=2 gives 4,1,4,1
    tick;
    rst_b = 1'b0; in_valid_b = 5'b10010;
    tick;
    chk("wrap_first", out_ch_b, 1);
    for (int k = 0; k < 4; k++) begin
      tick;
      chk($sformatf("wrap_ch%0d", k),   out_ch_b, (k % 2 == 0) ? 4 : 1);
      chk($sformatf("wrap_data%0d", k), out_data_b, (k % 2 == 0) ? 32'h204 : 32'h201);
    end

    // fixed select beyond NCH: no grant
    rr_en_b = 1'b0; s_b = 3'd6; in_valid_b = 5'h1f;
    #1 chk("oor_ready", in_ready_b, 0);
    tick;
    chk("oor_valid", out_valid_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data width per channel.
REQ-002 SHALL have parameter NCH, default 8, giving the channel count; legal range 2..16, and non-power-of-2 values SHALL be legal.
REQ-003 SHALL have derived localparam SELW = $clog2(NCH), the width of the channel index.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rr_en  input  1  1 = round-robin arbitration, 0 = fixed select via s.
REQ-007 s  input  SELW  fixed-mode channel index.
REQ-008 in_valid  input  NCH  per-channel data valid.
REQ-009 in_data  input  NCH*WIDTH  packed channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-010 in_ready  output  NCH  per-channel accept; combinational.
REQ-011 out_valid  output  1  registered output beat valid.
REQ-012 out_data  output  WIDTH  registered selected data.
REQ-013 out_ch  output  SELW  channel index of the current out_data.
REQ-014 out_ready  input  1  downstream accept.

Function
REQ-015 Transfer rules: an input transfer occurs when in_valid[i] && in_ready[i]; an output transfer occurs when out_valid && out_ready.
REQ-016 load = !out_valid || out_ready; the single output register SHALL accept a new beat only when load is 1.
REQ-017 Fixed mode (rr_en=0): grant = s; in_ready[s] = load; all other in_ready bits = 0. If s >= NCH, no grant and in_ready = 0.
REQ-018 Round-robin mode (rr_en=1): grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1; in_ready[grant] = load, others 0.
REQ-019 On an input transfer, the register SHALL capture in_data[grant] into out_data and grant into out_ch, and set out_valid=1; latency is 1 cycle from transfer to out_valid.
REQ-020 On an output transfer with no input transfer in the same cycle, out_valid SHALL go to 0 and out_data/out_ch SHALL hold.
REQ-021 Simultaneous output transfer and input transfer SHALL replace the beat in the same cycle with no bubble; full throughput is 1 beat/cycle.
REQ-022 ptr SHALL become grant+1 after each round-robin input transfer, wrapping from NCH-1 to 0; ptr is unchanged in fixed mode and on idle cycles.
REQ-023 No in_valid asserted: no transfer, in_ready = 0, state holds.
REQ-024 A change of rr_en or s SHALL take effect on the next arbitration; a held out beat is unaffected.
REQ-025 When out_valid=1 and out_ready=0, out_data, out_ch and out_valid SHALL remain stable.

Reset
REQ-026 While rst=1 at a clock edge: out_valid=0, out_data=0, out_ch=0, ptr=0, lock state cleared; in_ready SHALL be 0 while rst=1.
REQ-027 Reset mid-transfer SHALL discard the held beat, with no partial output.

Configuration
REQ-028 With macro RR_MUX_LOCK_EN defined, the block SHALL add port in_last (input, NCH wide). After a round-robin transfer with in_last[grant]=0, grant SHALL lock to that channel; other channels SHALL get in_ready=0 until that channel transfers with in_last=1. ptr SHALL advance only on that last beat, and fixed mode ignores the lock.
REQ-029 Without RR_MUX_LOCK_EN, the in_last port and the lock state SHALL be absent, and every beat SHALL be arbitrated independently.

Structure
REQ-030 Shared package rr_mux_pkg SHALL hold default WIDTH/NCH constants and the lock-state typedef.
REQ-031 Sub-module rr_arbiter (NCH, in_valid, ptr -> grant, any_valid) SHALL be the natural split; datapath and register stay in the top level.

Verification
REQ-032 Reset: hold rst 2 cycles with all in_valid=1 -> out_valid=0, out_data=0, in_ready=0, and the first post-reset grant is channel 0.
REQ-033 RR fairness: NCH=8, all in_valid=1, out_ready=1 -> out_ch sequence 0,1,...,7,0, one beat per cycle, out_data matching each channel.
REQ-034 Fixed select: rr_en=0, s=5, all valid, in_data[i]=32'h100+i -> out_data=32'h105 every cycle; in_ready=8'b0010_0000.
REQ-035 Backpressure: out_ready=0 for 4 cycles after a load -> out_data stable, in_ready=0; first cycle with out_ready=1 -> replace with no bubble.
REQ-036 Wrap and sparse: NCH=5, valid channels {1,4}, ptr=2 -> grants 4,1,4,1.
REQ-037 Lock (RR_MUX_LOCK_EN): channel 2 sends 3 beats (last on the 3rd) while channel 3 is valid -> out_ch 2,2,2,3.
